// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: datapath widths, ALU op codes and funct3 codes.
package id_ex_stage_pkg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0110;
    localparam logic [3:0] ALU_SUB = 4'b0111;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass for one source register: EX/MEM beats MEM/WB, x0 never bypassed.
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [RA_W-1:0] idx,
    input  logic [XLEN-1:0] reg_data,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] value
);
    always_comb begin
        value = reg_data;
        if (FWD_EN && idx != '0) begin
            if (exmem_reg_write && exmem_rd == idx)
                value = exmem_result;
            else if (memwb_reg_write && memwb_rd == idx)
                value = memwb_result;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select and load-use bubble insertion.
module id_ex_stage #(
    parameter int XLEN   = id_ex_stage_pkg::XLEN,
    parameter int RA_W   = id_ex_stage_pkg::RA_W,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_alu_src,
    input  logic [2:0]      id_funct,
    input  logic [3:0]      id_ALUcntl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [2:0]      ex_funct,
    output logic [3:0]      ex_ALUcntl,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_hazard
);
    import id_ex_stage_pkg::*;

    logic            valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q;
    logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic [2:0]      funct_q;
    logic [3:0]      alu_q;
    logic [XLEN-1:0] fwd1, fwd2;
    logic            bubble;

    // rs2 is consumed when it is an ALU operand or when it supplies store data.
    assign load_use_hazard = ex_mem_read && (rd_q != '0) && id_valid &&
                             ((rd_q == id_rs1) ||
                              ((rd_q == id_rs2) && (!id_alu_src || id_mem_write)));

    assign bubble = flush || (!stall && load_use_hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            funct_q     <= 3'b000;
            alu_q       <= ALU_AND;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= id_valid;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            alu_src_q   <= id_alu_src;
            funct_q     <= id_funct;
            alu_q       <= id_ALUcntl;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
            mem_write_q <= id_mem_write;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd1 (
        .idx(rs1_q), .reg_data(rs1_data_q),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .value(fwd1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd2 (
        .idx(rs2_q), .reg_data(rs2_data_q),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .value(fwd2)
    );

    assign ex_valid      = valid_q;
    assign ex_op1        = fwd1;
    assign ex_op2        = alu_src_q ? imm_q : fwd2;
    assign ex_store_data = fwd2;
    assign ex_funct      = funct_q;
    assign ex_ALUcntl    = alu_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = valid_q && reg_write_q;
    assign ex_mem_read   = valid_q && mem_read_q;
    assign ex_mem_write  = valid_q && mem_write_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized checks of id_ex_stage against an instruction-slot reference model.
module tb_id_ex_stage;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
    logic [2:0]  id_funct;
    logic [3:0]  id_ALUcntl;
    logic        exmem_reg_write, memwb_reg_write;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
    logic [31:0] ex_op1, ex_op2, ex_store_data;
    logic [2:0]  ex_funct;
    logic [3:0]  ex_ALUcntl;
    logic [4:0]  ex_rd;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_alu_src(id_alu_src),
        .id_funct(id_funct), .id_ALUcntl(id_ALUcntl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_store_data(ex_store_data),
        .ex_funct(ex_funct), .ex_ALUcntl(ex_ALUcntl), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently sitting in EX, as the ID stage handed it over.
    typedef struct {
        bit        valid, alu_src, rw, mr, mw;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
        bit [2:0]  funct;
        bit [3:0]  alu;
    } slot_t;

    slot_t m, empty_slot;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] fwd(input bit [4:0] s, input bit [31:0] d);
        if (s == 0) return d;
        if (exmem_reg_write && exmem_rd == s) return exmem_result;
        if (memwb_reg_write && memwb_rd == s) return memwb_result;
        return d;
    endfunction

    function automatic bit model_hazard();
        bit uses_rs1, uses_rs2;
        uses_rs1 = (m.rd == id_rs1);
        uses_rs2 = (m.rd == id_rs2) && (!id_alu_src || id_mem_write);
        return m.valid && m.mr && m.rd != 0 && id_valid && (uses_rs1 || uses_rs2);
    endfunction

    task automatic check_out();
        chk("ex_valid",      ex_valid, m.valid);
        chk("ex_rd",         ex_rd, m.rd);
        chk("ex_funct",      ex_funct, m.funct);
        chk("ex_ALUcntl",    ex_ALUcntl, m.alu);
        chk("ex_reg_write",  ex_reg_write, m.valid & m.rw);
        chk("ex_mem_read",   ex_mem_read, m.valid & m.mr);
        chk("ex_mem_write",  ex_mem_write, m.valid & m.mw);
        chk("ex_op1",        ex_op1, fwd(m.rs1, m.d1));
        chk("ex_op2",        ex_op2, m.alu_src ? m.imm : fwd(m.rs2, m.d2));
        chk("ex_store_data", ex_store_data, fwd(m.rs2, m.d2));
    endtask

    // One rising edge: check the hazard seen before it, then advance the model.
    task automatic tick();
        bit hz;
        hz = model_hazard();
        chk("load_use_hazard", load_use_hazard, hz);
        @(posedge clk);
        if (flush || (!stall && hz)) m = empty_slot;
        else if (!stall) begin
            m.valid = id_valid; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm; m.alu_src = id_alu_src;
            m.funct = id_funct; m.alu = id_ALUcntl; m.rw = id_reg_write;
            m.mr = id_mem_read; m.mw = id_mem_write;
        end
        #1;
    endtask

    task automatic set_nop();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_alu_src = 0; id_funct = 0; id_ALUcntl = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    task automatic drive_rand();
        id_valid = ($urandom_range(0, 7) != 0);
        id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7));
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_alu_src = 1'($urandom); id_funct = 3'($urandom); id_ALUcntl = 4'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
        id_mem_write = ($urandom_range(0, 3) == 0);
        exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom);
        exmem_result = $urandom;
        memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom);
        memwb_result = $urandom;
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        empty_slot = '{default: 0};
        m = empty_slot;
        set_nop();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_out();
        chk("reset_valid", ex_valid, 1'b0);
        chk("reset_alucntl", ex_ALUcntl, 4'b0000);

        // EX/MEM wins over MEM/WB for the same source
        id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h0000_1111; id_reg_write = 1; id_rd = 9;
        tick();
        exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'hAAAA_0000;
        memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h0000_1234;
        #1 chk("fwd_exmem_prio", ex_op1, 32'hAAAA_0000);
        check_out();

        // x0 is never forwarded
        set_nop(); id_valid = 1; id_rs2 = 0; id_rs2_data = 0;
        tick();
        exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hFFFF_FFFF;
        #1 chk("x0_no_fwd", ex_store_data, 32'h0);
        check_out();

        // Load-use: load to x7 in EX, consumer reads x7
        set_nop(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 7;
        tick();
        set_nop(); id_valid = 1; id_rs1 = 7; id_rd = 3; id_reg_write = 1; id_ALUcntl = 4'b0110;
        #1 chk("lu_hazard_hi", load_use_hazard, 1'b1);
        tick();
        chk("lu_bubble", ex_valid, 1'b0);
        chk("lu_hazard_lo", load_use_hazard, 1'b0);
        tick();
        chk("lu_reload_valid", ex_valid, 1'b1);
        chk("lu_reload_rd", ex_rd, 5'd3);
        check_out();

        // flush beats stall, then a held slot under pure stall
        stall = 1; flush = 1;
        tick();
        chk("flush_over_stall", ex_valid, 1'b0);
        stall = 0; flush = 0;
        set_nop(); id_valid = 1; id_rd = 12; id_reg_write = 1; id_funct = 3'b011;
        id_ALUcntl = 4'b0111; id_rs1 = 4; id_rs1_data = 32'hCAFE_F00D;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rd = 5'(20 + i); id_funct = 3'b010; id_rs1_data = $urandom;
            tick();
            chk("stall_rd", ex_rd, 5'd12);
            chk("stall_op1", ex_op1, 32'hCAFE_F00D);
            check_out();
        end
        stall = 0;

        // Immediate operand select
        set_nop(); id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFFC; id_ALUcntl = 4'b0110;
        id_rs2 = 6; id_rs2_data = 32'h55;
        tick();
        chk("imm_op2", ex_op2, 32'hFFFF_FFFC);
        chk("imm_alucntl", ex_ALUcntl, 4'b0110);
        chk("imm_store_data", ex_store_data, 32'h55);

        for (int i = 0; i < 400; i++) begin
            drive_rand();
            #1 check_out();
            tick();
            check_out();
        end
        stall = 0; flush = 0;

        // Reset asserted between edges clears the slot at once
        set_nop(); id_valid = 1; id_reg_write = 1; id_rs1 = 2; id_rs1_data = 32'h1357_9BDF;
        tick();
        chk("pre_reset_op1", ex_op1, 32'h1357_9BDF);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", ex_valid, 1'b0);
        chk("async_rst_reg_write", ex_reg_write, 1'b0);
        chk("async_rst_op1", ex_op1, 32'h0);
        m = empty_slot;
        @(posedge clk);
        #1 rst_n = 1;
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
